// File: rtl/pipelined_add_sub_if.sv
// Operand-issue / result-consumer bundle for pipelined_add_sub.
// The master side issues operands and accepts results; the slave side is the adder.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES
// carry-chained slices, one register stage per slice, valid/ready flow control.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int S = WIDTH / STAGES;

    logic              advance;
    logic              accept;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cry_q;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic              ovf_q;

    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic [WIDTH-1:0]  nxt_r [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] nxt_c;
    logic              nxt_ovf;
    logic [S:0]        slice;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance       = !vld_q[STAGES-1] || bus.out_ready;
    assign accept        = bus.in_valid && advance;

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = res_q[STAGES-1];
    assign bus.cout      = cry_q[STAGES-1];
    assign bus.ovf       = ovf_q;

    always_comb begin
        // Subtraction is A + ~B + 1, with cin acting as an active-high borrow.
        src_a[0] = bus.a;
        src_b[0] = bus.sub ? ~bus.b : bus.b;
        src_c[0] = bus.sub ^ bus.cin;
        src_r[0] = '0;
        src_v[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = opa_q[k-1];
            src_b[k] = opb_q[k-1];
            src_c[k] = cry_q[k-1];
            src_r[k] = res_q[k-1];
            src_v[k] = vld_q[k-1];
        end

        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, src_a[k][k*S +: S]} + {1'b0, src_b[k][k*S +: S]}
                  + {{S{1'b0}}, src_c[k]};
            nxt_r[k]            = src_r[k];
            nxt_r[k][k*S +: S]  = slice[S-1:0];
            nxt_c[k]            = slice[S];
        end

        // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry-out.
        nxt_ovf = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                ^ nxt_r[STAGES-1][WIDTH-1] ^ nxt_c[STAGES-1];
    end

    // Bubbles move the valid bits but leave the data registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= src_v;
            for (int k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    opa_q[k] <= src_a[k];
                    opb_q[k] <= src_b[k];
                    res_q[k] <= nxt_r[k];
                    cry_q[k] <= nxt_c[k];
                end
            end
            if (src_v[STAGES-1]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end
endmodule
